// File: rtl/bullet_collision_ctrl.sv
// Player bullet controller for an alien-formation shooter: spawns one bullet,
// moves it up once per frame, and tests it against the alien grid after each move.
module bullet_collision_ctrl #(
    parameter int AlienWidth         = 30,
    parameter int AlienHeight        = 20,
    parameter int AlienWidthSpacing  = 10,
    parameter int AlienHeightSpacing = 10,
    parameter int NumCols            = 10,
    parameter int NumRows            = 5,
    parameter int BulletWidth        = 4,
    parameter int BulletHeight       = 8,
    parameter int BulletSpeed        = 4,
    parameter int PlayerWidth        = 30
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         FrameTick,
    input  logic                         Fire,
    input  logic                         NewWave,
    input  logic [8:0]                   PlayerRow,
    input  logic [9:0]                   PlayerCol,
    input  logic [8:0]                   AliensRow,
    input  logic [9:0]                   AliensCol,
    output logic [8:0]                   BulletRow,
    output logic [9:0]                   BulletCol,
    output logic                         BulletExists,
    output logic [NumRows*NumCols-1:0]   Aliens_Grid,
    output logic                         KillPulse,
    output logic                         AllDead
);

    localparam int GridBits = NumRows * NumCols;
    localparam int IdxBits  = $clog2(GridBits);
    localparam int ColPitch = AlienWidth + AlienWidthSpacing;
    localparam int RowPitch = AlienHeight + AlienHeightSpacing;
    localparam logic [9:0] SpawnOffset = 10'(PlayerWidth / 2 - BulletWidth / 2);

    typedef enum logic [1:0] {IDLE, FLIGHT, CHECK} stateType;

    stateType              state, stateNext;
    logic [8:0]            rowNext;
    logic [9:0]            colNext;
    logic                  existsNext;
    logic [GridBits-1:0]   gridNext;
    logic                  killNext;

    logic [9:0]            testX, testY, dx, dy;
    logic [9:0]            colQuot, rowQuot, colRem, rowRem;
    logic [3:0]            hitCol, hitRow;
    logic [IdxBits-1:0]    hitIdx;
    logic [GridBits-1:0]   hitMask;
    logic                  inFormation, hit;

    // Collision test point: horizontal centre of the bullet, at its top edge.
    always_comb begin
        testX   = BulletCol + 10'(BulletWidth / 2);
        testY   = {1'b0, BulletRow};
        dx      = testX - AliensCol;
        dy      = testY - {1'b0, AliensRow};
        colQuot = dx / 10'(ColPitch);
        colRem  = dx % 10'(ColPitch);
        rowQuot = dy / 10'(RowPitch);
        rowRem  = dy % 10'(RowPitch);
        hitCol  = colQuot[3:0];
        hitRow  = rowQuot[3:0];
        hitIdx  = IdxBits'(int'(hitRow) * NumCols + int'(hitCol));
        hitMask = GridBits'(1) << hitIdx;
        // Range guards use the full-width quotients, so a wrapped 4-bit index can never alias a live cell.
        inFormation = (testX >= AliensCol) && (testY >= {1'b0, AliensRow})
                   && (colRem < 10'(AlienWidth)) && (rowRem < 10'(AlienHeight))
                   && (colQuot < 10'(NumCols)) && (rowQuot < 10'(NumRows));
        hit = inFormation && |(Aliens_Grid & hitMask);
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        stateNext  = state;
        rowNext    = BulletRow;
        colNext    = BulletCol;
        existsNext = BulletExists;
        gridNext   = Aliens_Grid;
        killNext   = 1'b0;

        if (NewWave) begin
            gridNext   = '1;
            existsNext = 1'b0;
            stateNext  = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (Fire && (PlayerRow >= 9'(BulletHeight))) begin
                        colNext    = PlayerCol + SpawnOffset;
                        rowNext    = PlayerRow - 9'(BulletHeight);
                        existsNext = 1'b1;
                        stateNext  = FLIGHT;
                    end
                end
                FLIGHT: begin
                    if (FrameTick) begin
                        if (BulletRow < 9'(BulletSpeed)) begin
                            existsNext = 1'b0;
                            stateNext  = IDLE;
                        end else begin
                            rowNext   = BulletRow - 9'(BulletSpeed);
                            stateNext = CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (hit) begin
                        gridNext   = Aliens_Grid & ~hitMask;
                        existsNext = 1'b0;
                        killNext   = 1'b1;
                        stateNext  = IDLE;
                    end else begin
                        stateNext = FLIGHT;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            BulletRow    <= '0;
            BulletCol    <= '0;
            BulletExists <= 1'b0;
            Aliens_Grid  <= '1;
            KillPulse    <= 1'b0;
        end else begin
            state        <= stateNext;
            BulletRow    <= rowNext;
            BulletCol    <= colNext;
            BulletExists <= existsNext;
            Aliens_Grid  <= gridNext;
            KillPulse    <= killNext;
        end
    end

    assign AllDead = ~|Aliens_Grid;

endmodule
